// File: rtl/column_stream_writer.sv
// Column record FIFO and serialiser feeding the VGA column decoder with four 16-bit write beats per column.
// Short frames are padded with ceiling-only columns so the frame always holds exactly NCOLS columns.
module column_stream_writer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BEAT_GAP = 0,
  parameter int unsigned NCOLS    = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic        in_side,
  input  logic [2:0]  in_tex_type,
  input  logic [5:0]  in_tex_col,
  input  logic [15:0] in_height,
  input  logic [15:0] in_top,
  input  logic [15:0] in_scale,
  output logic        write,
  output logic        chipselect,
  output logic [15:0] writedata,
  output logic [9:0]  col_count,
  output logic        frame_done,
  output logic        err_short,
  input  logic        err_clear
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(BEAT_GAP + 2);

  typedef struct packed {
    logic        side;
    logic [2:0]  tex_type;
    logic [5:0]  tex_col;
    logic [15:0] height;
    logic [15:0] top;
    logic [15:0] scale;
  } payload_t;

  typedef struct packed {
    logic     sof;
    payload_t pl;
  } rec_t;

  typedef enum logic [2:0] {IDLE, LOAD, BEAT, GAP, PAD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pad_q, pad_d;
  payload_t        rec_q, rec_d;
  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            write_q, write_d;
  logic [15:0]     writedata_q, writedata_d;
  logic [9:0]      col_count_q, col_count_d;
  logic            frame_done_q, frame_done_d;
  logic            err_short_q, err_short_d;

  logic            push, pop, fifo_ne, start_col, next_beat, err_set;
  rec_t            head, rec_in;
  logic [9:0]      col_bump;

  // Beat word for column position k; pad columns carry only a ceiling top.
  function automatic logic [15:0] beat_word(input payload_t p, input logic [1:0] k, input logic pad);
    logic [15:0] w;
    if (pad) begin
      w = (k == 2'd2) ? 16'h7FFF : 16'h0000;
    end else begin
      case (k)
        2'd0:    w = {6'b0, p.side, p.tex_type, p.tex_col};
        2'd1:    w = p.height;
        2'd2:    w = p.top;
        default: w = p.scale;
      endcase
    end
    return w;
  endfunction

  assign rec_in   = '{sof: in_sof, pl: '{side: in_side, tex_type: in_tex_type, tex_col: in_tex_col,
                                          height: in_height, top: in_top, scale: in_scale}};
  assign head     = mem_q[rd_ptr_q];
  assign fifo_ne  = (count_q != '0);
  assign push     = in_valid && in_ready_q;
  assign col_bump = (col_count_q == 10'(NCOLS - 1)) ? 10'd0 : col_count_q + 10'd1;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    pad_d        = pad_q;
    rec_d        = rec_q;
    write_d      = 1'b0;
    writedata_d  = 16'h0000;
    col_count_d  = col_count_q;
    start_col    = 1'b0;
    next_beat    = 1'b0;
    err_set      = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: if (fifo_ne) state_d = LOAD;
      LOAD: start_col = 1'b1;
      BEAT, PAD: begin
        if (BEAT_GAP == 0) begin
          if (beat_q == 2'd3) start_col = 1'b1;
          else                next_beat = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(BEAT_GAP - 1)) begin
          if (beat_q == 2'd3) start_col = 1'b1;
          else                next_beat = 1'b1;
        end else begin
          gap_d = GW'(gap_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (next_beat) begin
      beat_d      = beat_q + 2'd1;
      state_d     = pad_q ? PAD : BEAT;
      write_d     = 1'b1;
      writedata_d = beat_word(rec_q, beat_d, pad_q);
      if (beat_d == 2'd3) col_count_d = col_bump;
    end

    // Column boundary: a sof record arriving mid-frame stays queued while pad columns finish the frame.
    if (start_col) begin
      if (!fifo_ne) begin
        state_d = IDLE;
      end else if (head.sof && (col_count_q != 10'd0)) begin
        state_d     = PAD;
        pad_d       = 1'b1;
        beat_d      = 2'd0;
        write_d     = 1'b1;
        writedata_d = beat_word(head.pl, 2'd0, 1'b1);
        err_set     = !pad_q;
      end else begin
        pop         = 1'b1;
        rec_d       = head.pl;
        pad_d       = 1'b0;
        state_d     = BEAT;
        beat_d      = 2'd0;
        write_d     = 1'b1;
        writedata_d = beat_word(head.pl, 2'd0, 1'b0);
      end
    end

    frame_done_d = ((state_q == BEAT) || (state_q == PAD)) && (beat_q == 2'd3) && (col_count_q == 10'd0);
    err_short_d  = err_set ? 1'b1 : (err_clear ? 1'b0 : err_short_q);

    wr_ptr_d   = push ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = pop  ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d    = CW'(count_q + CW'(push) - CW'(pop));
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      gap_q        <= '0;
      pad_q        <= 1'b0;
      rec_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 16'h0000;
      col_count_q  <= 10'd0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      pad_q        <= pad_d;
      rec_q        <= rec_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      col_count_q  <= col_count_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      if (push) mem_q[wr_ptr_q] <= rec_in;
    end
  end

  assign in_ready   = in_ready_q;
  assign write      = write_q;
  assign chipselect = write_q;
  assign writedata  = writedata_q;
  assign col_count  = col_count_q;
  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;

endmodule

// File: tb/tb_column_stream_writer.sv
// Bench for column_stream_writer: a beat-stream model per instance (gap 0 / depth 16 and gap 2 / depth 4)
// checked every cycle, plus directed literal expectations.
module tb_column_stream_writer;

  localparam int NCOLS = 640;

  logic clk = 1'b0;
  logic reset;
  logic        iv [2], isof [2], iside [2], eclr [2];
  logic [2:0]  itype [2];
  logic [5:0]  icol [2];
  logic [15:0] ih [2], itop [2], isc [2];
  logic        rdy [2], wr [2], cs [2], fd [2], err [2];
  logic [15:0] wd [2];
  logic [9:0]  cc [2];

  always #5 clk = ~clk;

  column_stream_writer #(.DEPTH(16), .BEAT_GAP(0), .NCOLS(NCOLS)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .in_sof(isof[0]), .in_side(iside[0]),
    .in_tex_type(itype[0]), .in_tex_col(icol[0]), .in_height(ih[0]), .in_top(itop[0]), .in_scale(isc[0]),
    .write(wr[0]), .chipselect(cs[0]), .writedata(wd[0]), .col_count(cc[0]), .frame_done(fd[0]),
    .err_short(err[0]), .err_clear(eclr[0]));

  column_stream_writer #(.DEPTH(4), .BEAT_GAP(2), .NCOLS(NCOLS)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .in_sof(isof[1]), .in_side(iside[1]),
    .in_tex_type(itype[1]), .in_tex_col(icol[1]), .in_height(ih[1]), .in_top(itop[1]), .in_scale(isc[1]),
    .write(wr[1]), .chipselect(cs[1]), .writedata(wd[1]), .col_count(cc[1]), .frame_done(fd[1]),
    .err_short(err[1]), .err_clear(eclr[1]));

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int mcol [2], nwr [2], wcnt [2], fdcnt [2], first_w [2], last_w [2];
  bit fd_exp [2];
  int cyc, checks, errors;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic qpush(input int ch, input logic [15:0] w);
    if (ch == 0) q0.push_back(w);
    else         q1.push_back(w);
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  // Expected beat stream: every accepted record, preceded by pad columns if it starts a frame early.
  task automatic model_push(input int ch);
    if (isof[ch] && mcol[ch] != 0) begin
      while (mcol[ch] != 0) begin
        qpush(ch, 16'h0000); qpush(ch, 16'h0000); qpush(ch, 16'h7FFF); qpush(ch, 16'h0000);
        mcol[ch] = (mcol[ch] + 1) % NCOLS;
      end
    end
    qpush(ch, {6'b0, iside[ch], itype[ch], icol[ch]});
    qpush(ch, ih[ch]);
    qpush(ch, itop[ch]);
    qpush(ch, isc[ch]);
    mcol[ch] = (mcol[ch] + 1) % NCOLS;
  endtask

  task automatic step();
    logic acc0, acc1;
    logic [15:0] e;
    acc0 = iv[0] && rdy[0];
    acc1 = iv[1] && rdy[1];
    @(posedge clk);
    if (reset) begin
      q0.delete(); q1.delete();
      for (int c = 0; c < 2; c++) begin mcol[c] = 0; nwr[c] = 0; fd_exp[c] = 1'b0; end
    end else begin
      if (acc0) model_push(0);
      if (acc1) model_push(1);
    end
    #1;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("chipselect%0d", c), int'(cs[c]), int'(wr[c]));
      chk($sformatf("frame_done%0d", c), int'(fd[c]), int'(fd_exp[c]));
      fd_exp[c] = 1'b0;
      if (fd[c]) fdcnt[c]++;
      if (wr[c]) begin
        if (qsize(c) == 0) begin
          chk($sformatf("spurious_write%0d", c), 1, 0);
        end else begin
          e = (c == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("writedata%0d", c), int'(wd[c]), int'(e));
        end
        nwr[c]++; wcnt[c]++;
        if (first_w[c] < 0) first_w[c] = cyc;
        last_w[c] = cyc;
        if ((nwr[c] % 4 == 0) && ((nwr[c] / 4) % NCOLS == 0)) fd_exp[c] = 1'b1;
      end
      chk($sformatf("col_count%0d", c), int'(cc[c]), (nwr[c] / 4) % NCOLS);
    end
  endtask

  task automatic set_rec(input int ch, input logic sof, input logic side, input logic [2:0] ty,
                         input logic [5:0] col, input logic [15:0] h, input logic [15:0] top, input logic [15:0] sc);
    isof[ch] = sof; iside[ch] = side; itype[ch] = ty; icol[ch] = col; ih[ch] = h; itop[ch] = top; isc[ch] = sc;
  endtask

  task automatic gen(input int ch, input int i, input logic sof);
    set_rec(ch, sof, 1'(i % 2), 3'(i % 8), 6'(i % 64), 16'(i * 3 + 1), 16'(i - 300), 16'(i * 5 + 64));
  endtask

  task automatic send(input int ch);
    logic ok;
    int n;
    iv[ch] = 1'b1;
    n = 0;
    do begin
      ok = rdy[ch];
      step();
      n++;
    end while (!ok && n < 200);
    if (!ok) chk($sformatf("accept_timeout%0d", ch), n, -1);
  endtask

  task automatic drain(input int ch, input int budget);
    int n;
    n = 0;
    while ((qsize(ch) != 0 || wr[ch]) && n < budget) begin step(); n++; end
    if (n >= budget) chk($sformatf("drain_timeout%0d", ch), qsize(ch), 0);
  endtask

  task automatic clr_stats(input int ch);
    wcnt[ch] = 0; fdcnt[ch] = 0; first_w[ch] = -1; last_w[ch] = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("in_ready_in_reset", int'(rdy[0]), 0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int acc, stall, n;
    logic ok;
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      iv[c] = 1'b0; eclr[c] = 1'b0; mcol[c] = 0; nwr[c] = 0; fd_exp[c] = 1'b0;
      set_rec(c, 1'b0, 1'b0, 3'd0, 6'd0, 16'd0, 16'd0, 16'd0);
      clr_stats(c);
    end

    do_reset();
    chk("rst_in_ready", int'(rdy[0]), 1);
    chk("rst_write", int'(wr[0]), 0);
    chk("rst_writedata", int'(wd[0]), 0);
    chk("rst_col_count", int'(cc[0]), 0);
    chk("rst_err_short", int'(err[0]), 0);

    // Single record latency and beat contents
    set_rec(0, 1'b1, 1'b1, 3'd5, 6'd33, 16'd120, 16'hFFF8, 16'h0400);
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step(); chk("t1_n1_write", int'(wr[0]), 0);
    step(); chk("t1_b0_write", int'(wr[0]), 1); chk("t1_b0", int'(wd[0]), 16'h0361);
    step(); chk("t1_b1", int'(wd[0]), 16'h0078);
    step(); chk("t1_b2", int'(wd[0]), 16'hFFF8);
    step(); chk("t1_b3", int'(wd[0]), 16'h0400); chk("t1_col", int'(cc[0]), 1);
    step(); chk("t1_after_write", int'(wr[0]), 0);

    // Full frame streamed back to back
    do_reset();
    clr_stats(0);
    for (int i = 0; i < NCOLS; i++) begin gen(0, i, i == 0); send(0); end
    iv[0] = 1'b0;
    drain(0, 3000);
    chk("t2_writes", wcnt[0], 2560);
    chk("t2_span", last_w[0] - first_w[0] + 1, 2560);
    chk("t2_frame_done", fdcnt[0], 1);
    chk("t2_col", int'(cc[0]), 0);
    chk("t2_err", int'(err[0]), 0);

    // Short frame: 637 columns then an early sof
    clr_stats(0);
    for (int i = 0; i < 637; i++) begin gen(0, i + 7, i == 0); send(0); end
    gen(0, 999, 1'b1); send(0);
    iv[0] = 1'b0;
    drain(0, 3000);
    chk("t3_writes", wcnt[0], 2564);
    chk("t3_err", int'(err[0]), 1);
    chk("t3_col", int'(cc[0]), 1);
    chk("t3_frame_done", fdcnt[0], 1);
    eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
    chk("t3_err_cleared", int'(err[0]), 0);

    // Beat gap of 2 cycles
    do_reset();
    clr_stats(1);
    gen(1, 11, 1'b1);
    iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    chk("t5_write_0", int'(wr[1]), 0);
    for (int k = 1; k < 14; k++) begin
      step();
      chk($sformatf("t5_write_%0d", k), int'(wr[1]), (k == 2 || k == 5 || k == 8 || k == 11) ? 1 : 0);
    end
    drain(1, 50);

    // Backpressure while the serialiser is busy
    clr_stats(1);
    gen(1, 50, 1'b0); send(1);
    iv[1] = 1'b0;
    n = 0;
    while (!wr[1] && n < 20) begin step(); n++; end
    chk("t4_first_write", int'(wr[1]), 1);
    acc = 0; stall = -1;
    for (int i = 0; i < 7; i++) begin
      gen(1, 60 + i, 1'b0);
      iv[1] = 1'b1;
      n = 0;
      do begin
        ok = rdy[1];
        if (!ok && stall < 0) stall = acc;
        step();
        n++;
      end while (!ok && n < 100);
      if (!ok) chk("t4_accept_timeout", n, -1);
      acc++;
    end
    iv[1] = 1'b0;
    chk("t4_accepted_before_stall", stall, 4);
    drain(1, 400);
    chk("t4_writes", wcnt[1], 32);

    // Reset in the middle of a record
    do_reset();
    gen(0, 5, 1'b1); send(0);
    iv[0] = 1'b0;
    step(); step(); step();
    chk("t6_b1", int'(wd[0]), int'(ih[0]));
    reset = 1'b1;
    step();
    chk("t6_write_after_reset", int'(wr[0]), 0);
    chk("t6_col_after_reset", int'(cc[0]), 0);
    reset = 1'b0;
    step();
    gen(0, 6, 1'b0); send(0);
    iv[0] = 1'b0;
    step(); step();
    chk("t6_fresh_b0_write", int'(wr[0]), 1);
    chk("t6_fresh_b0", int'(wd[0]), 16'h0186);
    chk("t6_fresh_col", int'(cc[0]), 0);
    drain(0, 50);
    chk("t6_col_end", int'(cc[0]), 1);

    chk("end_queue0", qsize(0), 0);
    chk("end_queue1", qsize(1), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
